fp32_mul_chn_feeder: RTL and testbench

FP32_MUL_CHN_FEEDER -- requirements
Module: fp32_mul_chn_feeder

---
 rtl/fp32_mul_chn_feeder.sv | 137 +++++++++++++
 tb/tb_fp32_mul_chn_feeder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp32_mul_chn_feeder.sv
// Operand feeder for an fp32 multiplier with split A/B load channels and an
// in-order result FIFO; admission is credit-limited so products always fit.
module fp32_mul_chn_feeder #(
  parameter int DEPTH = 4
) (
  input  logic        nvdla_core_clk,
  input  logic        nvdla_core_rst,
  input  logic        req_pvld,
  output logic        req_prdy,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] chn_a_rsc_z,
  output logic        chn_a_rsc_vz,
  input  logic        chn_a_rsc_lz,
  output logic [31:0] chn_b_rsc_z,
  output logic        chn_b_rsc_vz,
  input  logic        chn_b_rsc_lz,
  input  logic [31:0] chn_o_rsc_z,
  input  logic        chn_o_rsc_lz,
  output logic        chn_o_rsc_vz,
  output logic        rsp_pvld,
  input  logic        rsp_prdy,
  output logic [31:0] rsp_data,
  output logic [4:0]  inflight,
  output logic        err_unexp
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  logic          a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic [31:0]   a_z_q, a_z_d, b_z_q, b_z_d;
  logic [4:0]    inflight_q, inflight_d, count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          err_q, err_d;
  logic [31:0]   mem_q [DEPTH];

  logic        accept_s, a_xfer_s, b_xfer_s, o_xfer_s, pop_s;
  logic [5:0]  occ_s;

  // Credits cover both outstanding operations and queued results, so a
  // returning product always finds FIFO space.
  assign occ_s        = {1'b0, inflight_q} + {1'b0, count_q};
  assign req_prdy     = !nvdla_core_rst && !a_pend_q && !b_pend_q && (occ_s < {1'b0, DEPTH_C});
  assign chn_o_rsc_vz = !nvdla_core_rst && (count_q < DEPTH_C);
  assign rsp_pvld     = !nvdla_core_rst && (count_q != 5'd0);
  assign rsp_data     = rsp_pvld ? mem_q[rd_ptr_q] : 32'd0;
  assign chn_a_rsc_z  = a_z_q;
  assign chn_b_rsc_z  = b_z_q;
  assign chn_a_rsc_vz = a_pend_q;
  assign chn_b_rsc_vz = b_pend_q;
  assign inflight     = inflight_q;
  assign err_unexp    = err_q;

  assign accept_s = req_pvld && req_prdy;
  assign a_xfer_s = chn_a_rsc_vz && chn_a_rsc_lz;
  assign b_xfer_s = chn_b_rsc_vz && chn_b_rsc_lz;
  assign o_xfer_s = chn_o_rsc_lz && chn_o_rsc_vz;
  assign pop_s    = rsp_pvld && rsp_prdy;

  always_comb begin
    a_pend_d   = a_pend_q;
    b_pend_d   = b_pend_q;
    a_z_d      = a_z_q;
    b_z_d      = b_z_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    err_d      = err_q;

    if (accept_s) begin
      a_pend_d = 1'b1;
      b_pend_d = 1'b1;
      a_z_d    = req_a;
      b_z_d    = req_b;
    end else begin
      if (a_xfer_s) a_pend_d = 1'b0;
      else          a_pend_d = a_pend_q;
      if (b_xfer_s) b_pend_d = 1'b0;
      else          b_pend_d = b_pend_q;
    end

    // A product with nothing outstanding is flagged and still queued, but
    // must not underflow the in-flight count.
    case ({accept_s, o_xfer_s})
      2'b10:   inflight_d = inflight_q + 5'd1;
      2'b01: begin
        if (inflight_q != 5'd0) inflight_d = inflight_q - 5'd1;
        else                    inflight_d = inflight_q;
      end
      default: inflight_d = inflight_q;
    endcase
    if (o_xfer_s && (inflight_q == 5'd0)) err_d = 1'b1;
    else                                  err_d = err_q;

    case ({o_xfer_s, pop_s})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    if (o_xfer_s) wr_ptr_d = wr_ptr_q + AW'(1);
    else          wr_ptr_d = wr_ptr_q;
    if (pop_s)    rd_ptr_d = rd_ptr_q + AW'(1);
    else          rd_ptr_d = rd_ptr_q;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      a_pend_q   <= 1'b0;
      b_pend_q   <= 1'b0;
      a_z_q      <= 32'd0;
      b_z_q      <= 32'd0;
      inflight_q <= 5'd0;
      count_q    <= 5'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      a_pend_q   <= a_pend_d;
      b_pend_q   <= b_pend_d;
      a_z_q      <= a_z_d;
      b_z_q      <= b_z_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: entries are only read once counted as valid.
  always_ff @(posedge nvdla_core_clk) begin
    if (o_xfer_s) mem_q[wr_ptr_q] <= chn_o_rsc_z;
  end

endmodule

// File: tb/tb_fp32_mul_chn_feeder.sv
// Directed self-checking bench for fp32_mul_chn_feeder (DEPTH = 4).
module tb_fp32_mul_chn_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_pvld, req_prdy;
  logic [31:0] req_a, req_b;
  logic [31:0] a_z, b_z, o_z;
  logic        a_vz, a_lz, b_vz, b_lz, o_lz, o_vz;
  logic        rsp_pvld, rsp_prdy;
  logic [31:0] rsp_data;
  logic [4:0]  inflight;
  logic        err_unexp;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] head;

  always #5 clk = ~clk;

  fp32_mul_chn_feeder #(.DEPTH(4)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .req_pvld(req_pvld), .req_prdy(req_prdy), .req_a(req_a), .req_b(req_b),
    .chn_a_rsc_z(a_z), .chn_a_rsc_vz(a_vz), .chn_a_rsc_lz(a_lz),
    .chn_b_rsc_z(b_z), .chn_b_rsc_vz(b_vz), .chn_b_rsc_lz(b_lz),
    .chn_o_rsc_z(o_z), .chn_o_rsc_lz(o_lz), .chn_o_rsc_vz(o_vz),
    .rsp_pvld(rsp_pvld), .rsp_prdy(rsp_prdy), .rsp_data(rsp_data),
    .inflight(inflight), .err_unexp(err_unexp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_pvld = 1'b0; req_a = 32'd0; req_b = 32'd0;
    a_lz = 1'b1; b_lz = 1'b1; o_lz = 1'b0; o_z = 32'd0; rsp_prdy = 1'b0;
    tick(); tick();
    chk("rst_req_prdy", {31'd0, req_prdy}, 32'd0);
    chk("rst_o_vz", {31'd0, o_vz}, 32'd0);
    chk("rst_rsp_pvld", {31'd0, rsp_pvld}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_inflight", {27'd0, inflight}, 32'd0);
    chk("rst_err", {31'd0, err_unexp}, 32'd0);
    chk("rst_ab_vz", {30'd0, a_vz, b_vz}, 32'd0);
    chk("rst_a_z", a_z, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_req_prdy", {31'd0, req_prdy}, 32'd1);
    chk("post_rst_o_vz", {31'd0, o_vz}, 32'd1);
    chk("idle_lz_no_effect", {30'd0, a_vz, b_vz}, 32'd0);

    // Single operation, both channels load together
    req_pvld = 1'b1; req_a = 32'h3F80_0000; req_b = 32'h4000_0000;
    tick();
    req_pvld = 1'b0;
    chk("single_a_z", a_z, 32'h3F80_0000);
    chk("single_b_z", b_z, 32'h4000_0000);
    chk("single_vz", {30'd0, a_vz, b_vz}, 32'd3);
    chk("single_inflight1", {27'd0, inflight}, 32'd1);
    chk("single_prdy_low", {31'd0, req_prdy}, 32'd0);
    tick();
    chk("single_vz_clr", {30'd0, a_vz, b_vz}, 32'd0);
    o_lz = 1'b1; o_z = 32'h4000_0000;
    tick();
    o_lz = 1'b0;
    chk("single_inflight0", {27'd0, inflight}, 32'd0);
    chk("single_rsp_pvld", {31'd0, rsp_pvld}, 32'd1);
    chk("single_rsp_data", rsp_data, 32'h4000_0000);
    rsp_prdy = 1'b1;
    tick();
    rsp_prdy = 1'b0;
    chk("single_popped", {31'd0, rsp_pvld}, 32'd0);

    // Skewed channel loads
    a_lz = 1'b0; b_lz = 1'b0;
    req_pvld = 1'b1; req_a = 32'h1111_1111; req_b = 32'h2222_2222;
    tick();
    req_pvld = 1'b0;
    chk("skew_vz_both", {30'd0, a_vz, b_vz}, 32'd3);
    a_lz = 1'b1;
    tick();
    a_lz = 1'b0;
    chk("skew_a_done", {30'd0, a_vz, b_vz}, 32'd1);
    tick(); tick();
    chk("skew_b_hold_vz", {31'd0, b_vz}, 32'd1);
    chk("skew_b_hold_z", b_z, 32'h2222_2222);
    chk("skew_prdy_low", {31'd0, req_prdy}, 32'd0);
    b_lz = 1'b1;
    tick();
    chk("skew_b_done", {31'd0, b_vz}, 32'd0);
    chk("skew_prdy_high", {31'd0, req_prdy}, 32'd1);
    a_lz = 1'b1;
    o_lz = 1'b1; o_z = 32'h3333_3333;
    tick();
    o_lz = 1'b0;
    chk("skew_rsp_data", rsp_data, 32'h3333_3333);
    chk("skew_inflight0", {27'd0, inflight}, 32'd0);
    rsp_prdy = 1'b1;
    tick();
    rsp_prdy = 1'b0;

    // Backpressure: fill to DEPTH
    for (int k = 0; k < 4; k++) begin
      req_pvld = 1'b1; req_a = 32'(k); req_b = 32'(k);
      tick();
      req_pvld = 1'b0;
      tick();
    end
    chk("bp_inflight4", {27'd0, inflight}, 32'd4);
    chk("bp_prdy_credit", {31'd0, req_prdy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      o_lz = 1'b1; o_z = 32'hA000_0000 + 32'(k);
      tick();
    end
    o_lz = 1'b0;
    chk("bp_inflight0", {27'd0, inflight}, 32'd0);
    chk("bp_full_prdy", {31'd0, req_prdy}, 32'd0);
    chk("bp_full_o_vz", {31'd0, o_vz}, 32'd0);
    chk("bp_head", rsp_data, 32'hA000_0000);
    tick();
    chk("bp_head_stable", rsp_data, 32'hA000_0000);
    rsp_prdy = 1'b1;
    tick();
    rsp_prdy = 1'b0;
    chk("bp_pop_prdy", {31'd0, req_prdy}, 32'd1);
    chk("bp_pop_o_vz", {31'd0, o_vz}, 32'd1);
    chk("bp_next", rsp_data, 32'hA000_0001);

    // Simultaneous push and pop with pointer wrap
    exp_q = {32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
    for (int j = 0; j < 3; j++) begin
      req_pvld = 1'b1; req_a = 32'h5000_0000 + 32'(j); req_b = req_a;
      tick();
      req_pvld = 1'b0;
      tick();
      o_lz = 1'b1; o_z = 32'hB000_0000 + 32'(j); rsp_prdy = 1'b1;
      exp_q.push_back(o_z);
      void'(exp_q.pop_front());
      tick();
      o_lz = 1'b0; rsp_prdy = 1'b0;
      chk("pp_head", rsp_data, exp_q[0]);
      chk("pp_count3_o_vz", {31'd0, o_vz}, 32'd1);
    end
    for (int j = 0; j < 3; j++) begin
      head = exp_q.pop_front();
      chk("pp_drain", rsp_data, head);
      rsp_prdy = 1'b1;
      tick();
      rsp_prdy = 1'b0;
    end
    chk("pp_empty", {31'd0, rsp_pvld}, 32'd0);

    // Unexpected product
    o_lz = 1'b1; o_z = 32'hDEAD_BEEF;
    tick();
    o_lz = 1'b0;
    chk("unexp_err", {31'd0, err_unexp}, 32'd1);
    chk("unexp_inflight", {27'd0, inflight}, 32'd0);
    chk("unexp_data", rsp_data, 32'hDEAD_BEEF);
    rsp_prdy = 1'b1;
    tick();
    rsp_prdy = 1'b0;
    chk("unexp_sticky", {31'd0, err_unexp}, 32'd1);

    // Reset mid-operation
    for (int k = 0; k < 3; k++) begin
      req_pvld = 1'b1; req_a = 32'h6000_0000; req_b = 32'h6000_0000;
      tick();
      req_pvld = 1'b0;
      tick();
    end
    o_lz = 1'b1; o_z = 32'h7000_0000;
    tick();
    chk("mid_inflight2", {27'd0, inflight}, 32'd2);
    chk("mid_fifo1", {31'd0, rsp_pvld}, 32'd1);
    rst = 1'b1; o_z = 32'h5555_5555;
    tick();
    chk("mid_rst_inflight", {27'd0, inflight}, 32'd0);
    chk("mid_rst_pvld", {31'd0, rsp_pvld}, 32'd0);
    chk("mid_rst_err", {31'd0, err_unexp}, 32'd0);
    tick();
    chk("mid_rst_ignored", {31'd0, rsp_pvld}, 32'd0);
    rst = 1'b0; o_lz = 1'b0;
    tick();
    chk("mid_after_pvld", {31'd0, rsp_pvld}, 32'd0);
    chk("mid_after_inflight", {27'd0, inflight}, 32'd0);
    chk("mid_after_prdy", {31'd0, req_prdy}, 32'd1);
    o_lz = 1'b1; o_z = 32'h7777_7777;
    tick();
    o_lz = 1'b0;
    chk("mid_after_push", rsp_data, 32'h7777_7777);
    chk("mid_after_err", {31'd0, err_unexp}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
